regfile_wb_queue: RTL and testbench
===================================

Name: regfile_wb_queue

Overview:
- Write-side companion to the 32x64 register file: buffers writeback requests from the datapath and multi-cycle units (load, multiply) in a FIFO.
- Drains at most one entry per cycle onto the register file write port (write enable / Rd / data).
- Filters writes to X31 (XZR).
- Offers a lookup port so readers can forward values still pending in the queue.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
DW, 64, data width
AW, 5, register index width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  writeback request valid
req_ready  out  1  queue can accept a request (combinational)
req_rd  in  AW  destination register index
req_data  in  DW  writeback value
wr_hold  in  1  pause draining; contents retained
wr_en  out  1  register file write enable (registered)
wr_rd  out  AW  register file destination index (registered)
wr_data  out  DW  register file write data (registered)
count  out  $clog2(DEPTH)+1  entries currently queued
empty  out  1  count == 0
full  out  1  count == DEPTH
lk_rn  in  AW  lookup register index
lk_hit  out  1  lookup matched a pending write
lk_data  out  DW  forwarded value when lk_hit

Behaviour:
- Reset (rst_n low at a rising edge):
  - wr_en=0, wr_rd=0, wr_data=0.
  - Read/write pointers and count cleared, so empty=1 and full=0.
- During reset, req_ready=0 and nothing is accepted.
- Reset mid-operation discards all queued entries and any output-stage write; no partial write is issued.
- req_ready = rst_n & ~full. It depends only on full, so when full a same-cycle pop does not open a slot for a same-cycle push.
- Accept: req_valid & req_ready at a rising edge.
  - If req_rd != 31: entry {req_rd, req_data} written at the tail, tail pointer advances, count +1.
  - If req_rd == 31: request handshakes normally but is discarded; count unchanged.
- Drain: at each rising edge with count > 0 and wr_hold == 0:
  - Head entry moves to the output registers; wr_en=1 for the following cycle; head pointer advances; count -1.
  - Otherwise wr_en=0 next cycle, and wr_rd/wr_data hold their last values.
- Simultaneous accept and drain (not full, not empty): count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Entries leave in strict FIFO order; the same Rd may appear multiple times, and the later write lands later.
- Latency with an empty queue:
  - Request accepted at edge N; wr_en high during the cycle after edge N+1.
  - Register file captures the value at edge N+2.
- wr_hold asserted: no drain; accepts continue until full. Deasserting resumes draining at the next edge.
- wr_en never asserts with wr_rd == 31.
- count, empty and full are registered-state derived; no glitching on the request inputs.

Optional Feature:
WB_FWD_EN
- Defined: lk_hit/lk_data are combinational.
  - Search all valid queue entries plus the output stage (when wr_en=1) for Rd == lk_rn.
  - The youngest match wins: queue tail side first, output stage last.
  - lk_rn == 31 gives lk_hit=0, lk_data=0.
  - A request being accepted in the current cycle is not visible until it is stored.
- Not defined: lk_hit=0 and lk_data=0 constantly; lk_rn ignored; no comparators synthesised.

Test Plan:
- Reset, then a single request rd=5, data=0x1234 at edge 1 -> wr_en=1, wr_rd=5, wr_data=0x1234 during cycle after edge 2; empty=1 afterwards.
- wr_hold=1, push rd=1..5 with data 0x11..0x55 back-to-back -> first 4 accepted, full=1, req_ready=0 on the 5th. Release hold -> writes to rd 1,2,3,4 on 4 consecutive cycles, then count=0.
- Push rd=31, data=0xFFFF -> handshake completes, count stays 0, wr_en never asserts.
- Continuous push and drain for 10 cycles (hold=0) -> count stays at 1, pointers wrap past DEPTH, and the output sequence matches the input order exactly.
- WB_FWD_EN, hold=1, push rd=7/0xA then rd=7/0xB; lk_rn=7 -> lk_hit=1, lk_data=0xB. lk_rn=8 -> lk_hit=0. Without the macro -> lk_hit=0 in all cases.
- Three entries queued, rst_n=0 for one edge -> count=0, wr_en=0 next cycle, and no write to any queued rd ever appears.

Source files
------------

// File: rtl/regfile_wb_queue_if.sv
// Writeback request / register-file write bus shared by the producers and the
// writeback queue. The queue side uses the slave modport.
interface regfile_wb_queue_if #(
    parameter int DW = 64,
    parameter int AW = 5
) ();
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_rd;
    logic [DW-1:0] req_data;
    logic          wr_en;
    logic [AW-1:0] wr_rd;
    logic [DW-1:0] wr_data;

    modport master (
        output req_valid, req_rd, req_data,
        input  req_ready, wr_en, wr_rd, wr_data
    );

    modport slave (
        input  req_valid, req_rd, req_data,
        output req_ready, wr_en, wr_rd, wr_data
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// Writeback FIFO in front of the register file write port; drops X31 writes.
// Optional macro WB_FWD_EN enables the combinational forwarding lookup port.
module regfile_wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 64,
    parameter int AW    = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    regfile_wb_queue_if.slave        bus,
    input  logic                     wr_hold,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    input  logic [AW-1:0]            lk_rn,
    output logic                     lk_hit,
    output logic [DW-1:0]            lk_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AW-1:0] XZR = {AW{1'b1}};

    logic [AW-1:0] rd_mem_r   [DEPTH];
    logic [DW-1:0] data_mem_r [DEPTH];
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;

    logic          full_s;
    logic          empty_s;
    logic          accept_s;
    logic          push_s;
    logic          pop_s;

    assign full_s   = (count_r == CW'(DEPTH));
    assign empty_s  = (count_r == {CW{1'b0}});
    // Ready looks only at full, so a pop never frees a slot for a push in the same cycle.
    assign bus.req_ready = rst_n & ~full_s;
    assign accept_s = bus.req_valid & bus.req_ready;
    assign push_s   = accept_s & (bus.req_rd != XZR);
    assign pop_s    = ~empty_s & ~wr_hold;

    assign count = count_r;
    assign empty = empty_s;
    assign full  = full_s;

    // Queue storage: tail write on push; storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (push_s && rst_n) begin
            rd_mem_r[tail_r]   <= bus.req_rd;
            data_mem_r[tail_r] <= bus.req_data;
        end else begin
            rd_mem_r[tail_r]   <= rd_mem_r[tail_r];
            data_mem_r[tail_r] <= data_mem_r[tail_r];
        end
    end

    // Pointers, occupancy and the registered register-file write stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_r      <= {PW{1'b0}};
            tail_r      <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            bus.wr_en   <= 1'b0;
            bus.wr_rd   <= {AW{1'b0}};
            bus.wr_data <= {DW{1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + 1'b1;
            end else begin
                tail_r <= tail_r;
            end
            if (pop_s) begin
                bus.wr_en   <= 1'b1;
                bus.wr_rd   <= rd_mem_r[head_r];
                bus.wr_data <= data_mem_r[head_r];
                head_r      <= head_r + 1'b1;
            end else begin
                bus.wr_en   <= 1'b0;
                bus.wr_rd   <= bus.wr_rd;
                bus.wr_data <= bus.wr_data;
                head_r      <= head_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef WB_FWD_EN
    // Youngest-match forwarding: scan oldest to youngest so later hits override.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = {DW{1'b0}};
        if (lk_rn == XZR) begin
            lk_hit  = 1'b0;
            lk_data = {DW{1'b0}};
        end else begin
            if (bus.wr_en && (bus.wr_rd == lk_rn)) begin
                lk_hit  = 1'b1;
                lk_data = bus.wr_data;
            end else begin
                lk_hit  = 1'b0;
                lk_data = {DW{1'b0}};
            end
            for (int i = 0; i < DEPTH; i++) begin
                if ((CW'(i) < count_r) && (rd_mem_r[head_r + PW'(i)] == lk_rn)) begin
                    lk_hit  = 1'b1;
                    lk_data = data_mem_r[head_r + PW'(i)];
                end else begin
                    lk_hit  = lk_hit;
                    lk_data = lk_data;
                end
            end
        end
    end
`else
    logic unused_lk_s;
    assign unused_lk_s = ^lk_rn;
    assign lk_hit      = 1'b0;
    assign lk_data     = {DW{1'b0}};
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: directed steps plus random traffic
// compared against a queue-based reference model.
module tb_regfile_wb_queue;
    localparam int DEPTH = 4;
    localparam int DW    = 64;
    localparam int AW    = 5;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    logic                   clk;
    logic                   rst_n;
    logic                   wr_hold;
    logic [$clog2(DEPTH):0] count;
    logic                   empty;
    logic                   full;
    logic [AW-1:0]          lk_rn;
    logic                   lk_hit;
    logic [DW-1:0]          lk_data;

    int total;
    int bad;

    ent_t          q[$];
    logic          e_en;
    logic [AW-1:0] e_rd;
    logic [DW-1:0] e_data;
    int            accepted;

    regfile_wb_queue_if #(.DW(DW), .AW(AW)) bus ();

    regfile_wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .wr_hold (wr_hold),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .lk_rn   (lk_rn),
        .lk_hit  (lk_hit),
        .lk_data (lk_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive at the falling edge, check combinational outputs, advance the
    // model at the rising edge, then check registered outputs at the next falling edge.
    task automatic step(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d,
                        input logic h, input logic [AW-1:0] lk, input logic rn);
        logic          exp_hit;
        logic [DW-1:0] exp_lk;
        logic          acc;
        rst_n         = rn;
        bus.req_valid = v;
        bus.req_rd    = rd;
        bus.req_data  = d;
        wr_hold       = h;
        lk_rn         = lk;
        #1;
        chk("req_ready", {63'd0, bus.req_ready}, {63'd0, (rn && (q.size() < DEPTH))});
        exp_hit = 1'b0;
        exp_lk  = 64'd0;
`ifdef WB_FWD_EN
        if (lk != 5'd31) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (!exp_hit && q[i].rd == lk) begin
                    exp_hit = 1'b1;
                    exp_lk  = q[i].data;
                end
            end
            if (!exp_hit && e_en && e_rd == lk) begin
                exp_hit = 1'b1;
                exp_lk  = e_data;
            end
        end
`endif
        chk("lk_hit", {63'd0, lk_hit}, {63'd0, exp_hit});
        chk("lk_data", lk_data, exp_lk);
        @(posedge clk);
        if (!rn) begin
            q.delete();
            e_en   = 1'b0;
            e_rd   = 5'd0;
            e_data = 64'd0;
        end else begin
            acc = v && (q.size() < DEPTH);
            if (q.size() > 0 && !h) begin
                e_en   = 1'b1;
                e_rd   = q[0].rd;
                e_data = q[0].data;
                void'(q.pop_front());
            end else begin
                e_en = 1'b0;
            end
            if (acc) accepted++;
            if (acc && rd != 5'd31) q.push_back('{rd, d});
        end
        @(negedge clk);
        chk("wr_en", {63'd0, bus.wr_en}, {63'd0, e_en});
        chk("wr_rd", {59'd0, bus.wr_rd}, {59'd0, e_rd});
        chk("wr_data", bus.wr_data, e_data);
        chk("count", {61'd0, count}, 64'(q.size()));
        chk("empty", {63'd0, empty}, {63'd0, (q.size() == 0)});
        chk("full", {63'd0, full}, {63'd0, (q.size() == DEPTH)});
        chk("no_xzr_write", {63'd0, (bus.wr_en && bus.wr_rd == 5'd31)}, 64'd0);
    endtask

    task automatic idle(input int n, input logic h);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 64'd0, h, 5'd0, 1'b1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        accepted = 0;
        e_en = 1'b0;
        e_rd = 5'd0;
        e_data = 64'd0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_rd = 5'd0;
        bus.req_data = 64'd0;
        wr_hold = 1'b0;
        lk_rn = 5'd0;
        @(negedge clk);

        // Reset state
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0);
        step(1'b1, 5'd3, 64'd9, 1'b0, 5'd0, 1'b0);
        chk("rst_empty", {63'd0, empty}, 64'd1);
        chk("rst_wr_en", {63'd0, bus.wr_en}, 64'd0);

        // Single request and its two-edge latency
        step(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 1'b1);
        chk("lat_not_yet", {63'd0, bus.wr_en}, 64'd0);
        idle(1, 1'b0);
        chk("lat_wr_rd", {59'd0, bus.wr_rd}, 64'd5);
        chk("lat_wr_data", bus.wr_data, 64'h1234);
        idle(2, 1'b0);

        // Hold: fill to full, fifth request refused, then drain in order
        for (int i = 1; i <= 5; i++)
            step(1'b1, 5'(i), 64'(i * 8'h11), 1'b1, 5'd0, 1'b1);
        chk("hold_full", {63'd0, full}, 64'd1);
        idle(6, 1'b0);

        // XZR request handshakes but never writes
        accepted = 0;
        step(1'b1, 5'd31, 64'hFFFF, 1'b0, 5'd31, 1'b1);
        chk("xzr_accepted", 64'(accepted), 64'd1);
        chk("xzr_count", {61'd0, count}, 64'd0);
        idle(3, 1'b0);

        // Continuous push and drain, pointers wrap
        for (int i = 0; i < 10; i++)
            step(1'b1, 5'($urandom_range(30)), {$urandom, $urandom}, 1'b0, 5'd0, 1'b1);
        idle(3, 1'b0);

        // Forwarding with duplicate Rd
        step(1'b1, 5'd7, 64'hA, 1'b1, 5'd7, 1'b1);
        step(1'b1, 5'd7, 64'hB, 1'b1, 5'd7, 1'b1);
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 1'b1);
        step(1'b0, 5'd0, 64'd0, 1'b1, 5'd8, 1'b1);
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd7, 1'b1);
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd7, 1'b1);
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd7, 1'b1);

        // Reset with three entries queued discards them
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'(10 + i), 64'(100 + i), 1'b1, 5'd11, 1'b1);
        step(1'b0, 5'd0, 64'd0, 1'b0, 5'd11, 1'b0);
        chk("rst_mid_count", {61'd0, count}, 64'd0);
        idle(5, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(3) != 0),
                 ($urandom_range(7) == 0) ? 5'd31 : 5'($urandom_range(12)),
                 {$urandom, $urandom},
                 ($urandom_range(3) == 0),
                 5'($urandom_range(12)) | (($urandom_range(15) == 0) ? 5'd31 : 5'd0),
                 ($urandom_range(60) != 0));
        end
        idle(6, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
